// File: rtl/imem_pkg.sv
// imem_pkg: types and constants shared by the instruction-memory loader,
// the instruction memory and the PC logic.
package imem_pkg;

    localparam int unsigned WORD_W   = 32;
    localparam logic [31:0] RESET_PC = 32'h8000_0000;

    typedef enum logic [2:0] {
        ST_LEN,
        ST_DATA,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// byte_packer: assembles four accepted bytes, LSB first, into a 32-bit word.
// word_valid is a combinational pulse in the cycle the fourth byte is
// accepted; word is valid in that same cycle.
module byte_packer
    import imem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              word_valid,
    output logic [WORD_W-1:0] word
);

    logic [1:0]  count;
    logic [23:0] low_bytes;

    // Count accepted bytes and shift them in from the top so the first byte ends in [7:0].
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= '0;
            low_bytes <= '0;
        end else if (clear) begin
            count     <= '0;
            low_bytes <= '0;
        end else if (byte_valid) begin
            count     <= count + 2'd1;
            low_bytes <= {byte_data, low_bytes[23:8]};
        end
    end

    // The fourth byte completes the word directly without waiting for the register.
    always_comb begin
        word_valid = byte_valid && (count == 2'd3);
        word       = {byte_data, low_bytes};
    end

endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time writer for the instruction memory. Receives a 4-byte
// word count followed by little-endian instruction words and writes them from
// BASE_ADDR upwards, holding the core in reset until the load completes.
// Optional feature: define IMEM_LOADER_CHECKSUM_EN to require a trailing
// 32-bit wrapping-sum checksum word before declaring success.
module imem_loader
    import imem_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DEPTH     = 3000,
    parameter logic [31:0] BASE_ADDR = RESET_PC
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             rx_valid,
    input  logic [7:0]       rx_data,
    output logic             rx_ready,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [31:0]      mem_wdata,
    output logic             cpu_hold,
    output logic             busy,
    output logic             done,
    output logic             error
);

    localparam logic [WIDTH-1:0] BASE = WIDTH'(BASE_ADDR);

    state_t      state;
    state_t      state_next;
    logic        packer_clear;
    logic        byte_take;
    logic        word_valid;
    logic [31:0] word;
    logic [31:0] len;
    logic [31:0] idx;
    logic        last_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] sum;
`endif

    assign rx_ready  = !rst && (state == ST_LEN || state == ST_DATA || state == ST_CSUM);
    assign byte_take = rx_valid && rx_ready;
    assign last_word = (idx == len - 32'd1);

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clear      (packer_clear),
        .byte_valid (byte_take),
        .byte_data  (rx_data),
        .word_valid (word_valid),
        .word       (word)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_LEN;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode on completed words and re-arm requests.
    always_comb begin
        state_next   = state;
        packer_clear = 1'b0;
        case (state)
            ST_LEN: begin
                if (word_valid) begin
                    if (word == 32'd0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_next = ST_CSUM;
`else
                        state_next = ST_DONE;
`endif
                    end else if (word > DEPTH) begin
                        state_next = ST_ERR;
                    end else begin
                        state_next = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (word_valid && last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_next = ST_CSUM;
`else
                    state_next = ST_DONE;
`endif
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (word_valid) begin
                    state_next = (word == sum) ? ST_DONE : ST_ERR;
                end
            end
`endif
            ST_DONE, ST_ERR: begin
                if (start) begin
                    state_next   = ST_LEN;
                    packer_clear = 1'b1;
                end
            end
            default: state_next = ST_LEN;
        endcase
    end

    // Registered outputs follow the next state so status flags line up with the final write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            len       <= '0;
            idx       <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= BASE;
            mem_wdata <= '0;
            cpu_hold  <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum       <= '0;
`endif
        end else begin
            mem_we   <= 1'b0;
            cpu_hold <= (state_next != ST_DONE);
            busy     <= (state_next == ST_DATA) || (state_next == ST_CSUM);
            done     <= (state_next == ST_DONE);
            error    <= (state_next == ST_ERR);
            if (state == ST_LEN && word_valid) begin
                len <= word;
                idx <= '0;
            end
            if (state == ST_DATA && word_valid) begin
                mem_we    <= 1'b1;
                mem_addr  <= BASE + WIDTH'(idx << 2);
                mem_wdata <= word;
                idx       <= idx + 32'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
                sum       <= sum + word;
`endif
            end
            if (packer_clear) begin
                idx <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                sum <= '0;
`endif
            end
        end
    end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time writer for the instruction memory: accepts a byte stream (typically from a UART receiver) carrying a length header and little-endian 32-bit instruction words, and writes them into the writable instruction memory image starting at the reset PC. It sits between the serial front end and the instruction memory's write port. It holds the core in reset while loading, then releases it.

## Interface
- WIDTH, 32, address/data width of the memory write port
- DEPTH, 3000, instruction memory capacity in words; larger lengths are rejected
- BASE_ADDR, 32'h8000_0000, byte address of word 0 (reset PC)

- clk  in  1  system clock; single clock domain
- rst  in  1  reset, asynchronous, active-high
- start  in  1  one-cycle pulse; re-arms loader from DONE or ERR
- rx_valid  in  1  byte available on rx_data
- rx_data  in  8  stream byte
- rx_ready  out  1  loader accepts byte; transfer when rx_valid && rx_ready
- mem_we  out  1  one-cycle write strobe to instruction memory
- mem_addr  out  WIDTH  byte address of write (word aligned)
- mem_wdata  out  32  instruction word
- cpu_hold  out  1  keeps core in reset while loading
- busy  out  1  load in progress
- done  out  1  level; load completed successfully
- error  out  1  level; length or checksum failure

## Operation
- States: LEN (collect 4-byte word count N, LSB first), DATA (collect N words), CSUM (macro only), DONE, ERR.
- After reset: state LEN, byte count 0, word index 0.
- Bytes assemble little-endian: first byte -> [7:0], fourth -> [31:24].
- LEN complete: N == 0 -> DONE; N > DEPTH -> ERR, no writes; else DATA.
- Each completed word i: mem_we pulse, mem_addr = BASE_ADDR + 4*i, mem_wdata = word; i wraps never (bounded by N <= DEPTH).
- After word N-1 written: CSUM if CHECKSUM enabled, else DONE.
- rx_ready = 1 in LEN, DATA, CSUM; 0 in DONE, ERR.
- cpu_hold = 1 in all states except DONE. busy = 1 in DATA and CSUM.
- start in DONE or ERR: clear done/error, counters, go to LEN. start in LEN/DATA/CSUM ignored.
- Partial word at any abort point is discarded, never written.

## Timing
- Reset values: rx_ready 0 during reset then 1 in LEN, mem_we 0, mem_addr BASE_ADDR, mem_wdata 0, cpu_hold 1, busy 0, done 0, error 0.
- All outputs registered except rx_ready (decoded from state).
- mem_we asserted exactly the cycle after the 4th byte of a word is accepted; held one cycle.
- One byte accepted per cycle max; back-to-back rx_valid sustains 1 word per 4 cycles.
- done/error assert the cycle after the final accepted byte (or after final mem_we, whichever later); cpu_hold deasserts same cycle as done.
- rst mid-load: outputs immediately to reset values, memory contents already written are left untouched.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined: after N words, 4 more bytes form an expected checksum = 32-bit wrapping sum of all N words; match -> DONE, mismatch -> ERR. N == 0 expects checksum 0.
- Not defined: no CSUM state; DATA goes directly to DONE; checksum logic absent.

## Structure
- Shared package imem_pkg: state enum type, RESET_PC (32'h8000_0000) constant, word-width constant; also usable by instruction memory and PC logic.
- Sub-module byte_packer: 2-bit byte counter + 32-bit shift/assemble register, outputs word_valid pulse and word; clear input for re-arm/abort.

## Test plan
- Stream N=2, words 0x00000013, 0x00100093 -> mem_we at 0x80000000 then 0x80000004 with those data, done=1, cpu_hold=0.
- N=0 -> no mem_we, done=1 one cycle after 4th header byte.
- N=3001 (DEPTH+1) -> error=1, rx_ready=0, no mem_we; start pulse -> back to LEN, error=0.
- rx_valid toggling every other cycle with N=1, word 0xDEADBEEF -> single write of 0xDEADBEEF at 0x80000000.
- Assert rst after 6 data bytes of N=2 -> no second write, all outputs at reset values, fresh header load succeeds.
- With IMEM_LOADER_CHECKSUM_EN: words above + checksum 0x001000A6 -> done; checksum 0x001000A7 -> error, both words still written.
